uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter LD_BYTES, default 4, giving the number of bytes per loader word, sent LSB first.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the sent-byte counter.
REQ-003 Port CLK  in  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 Port RST_X  in  1  is the reset: synchronous, active-low.
REQ-005 Port ld_valid  in  1  indicates a loader word is available.
REQ-006 Port ld_data  in  8*LD_BYTES  carries the loader word.
REQ-007 Port ld_ready  out  1  signals word accepted; a transfer occurs when ld_valid and ld_ready are both high.
REQ-008 Port con_valid  in  1  indicates a console byte is available.
REQ-009 Port con_data  in  8  carries the console byte.
REQ-010 Port con_ready  out  1  signals byte accepted; a transfer occurs when con_valid and con_ready are both high.
REQ-011 Port tx_ready  in  1  is the idle flag from the shared UartTx.
REQ-012 Port tx_we  out  1  is a single-cycle write strobe to UartTx.
REQ-013 Port tx_data  out  8  is the byte presented with tx_we.
REQ-014 Port busy  out  1  SHALL be high when state is not IDLE or tx_we is high.
REQ-015 Port owner  out  1  gives the current or last granted requester (0 = loader, 1 = console).
REQ-016 Port sent_cnt  out  CNT_W  counts tx_we strobes.

Function
REQ-017 The FSM SHALL have states IDLE, LD_WAIT and LD_SEND; console transfers SHALL complete from IDLE.
REQ-018 Acceptance SHALL be allowed only when state==IDLE, tx_ready==1 and tx_we==0.
REQ-019 ld_ready and con_ready SHALL be combinational, with at most one high per cycle.
REQ-020 Arbitration SHALL be round-robin at transaction granularity (loader = whole word, console = one byte): when both requesters are valid, the one not last served wins; a lone requester always wins.
REQ-021 Console accept in cycle N: tx_data=con_data and tx_we=1 in cycle N+1, owner=1, state stays IDLE.
REQ-022 Loader accept in cycle N: capture the word and set remaining=LD_BYTES-1; tx_data=ld_data[7:0] and tx_we=1 in cycle N+1, owner=0, state becomes LD_WAIT.
REQ-023 LD_WAIT: the block SHALL ignore tx_ready in the tx_we cycle; at the first later cycle with tx_ready=1 it SHALL emit the next byte (tx_we=1 the following cycle) and decrement remaining.
REQ-024 After the tx_we of the last loader byte the state SHALL return to IDLE.
REQ-025 The console SHALL never be granted while a loader word is partially sent.
REQ-026 tx_we SHALL never be high in two consecutive cycles.
REQ-027 tx_data SHALL hold its value when tx_we=0.
REQ-028 sent_cnt SHALL increment by 1 per tx_we and wrap modulo 2^CNT_W.
REQ-029 If tx_ready stays 0, the block SHALL hold its state indefinitely with no timeout.
REQ-030 If ld_valid drops in IDLE before acceptance, no grant SHALL be issued and the round-robin pointer SHALL be unchanged.

Reset
REQ-031 When RST_X=0 at a clock edge: state=IDLE, tx_we=0, tx_data=0, ld_ready=con_ready=0, owner=1 (so the loader wins the first tie), sent_cnt=0, and remaining=0.
REQ-032 A reset mid-word SHALL discard the unsent bytes; no byte SHALL be emitted in the first cycle after RST_X rises.

Structure
REQ-033 Package uart_arb_pkg SHALL hold the state enum (IDLE, LD_WAIT, LD_SEND) and the owner encodings OWN_LD and OWN_CON.
REQ-034 Sub-module word_ser SHALL be used for the loader shift register and remaining-byte counter (load, shift, last outputs); arbitration and the FSM SHALL stay in the top level.

Verification
REQ-035 After reset, tx_ready=1, ld_valid with ld_data=32'h04030201 -> tx_we pulses with bytes 01,02,03,04 in order, each separated by a tx_ready low-to-high cycle; sent_cnt=4.
REQ-036 ld_valid and con_valid both high continuously with con_data=8'h41 -> order word(4 bytes), 41, word, 41; ld_ready and con_ready are never high together.
REQ-037 con_valid raised while loader byte 2 is pending -> con_ready stays 0 until after the tx_we of byte 4, then 8'h41 is sent next.
REQ-038 tx_ready held low for 100 cycles mid-word -> no tx_we and busy=1; tx_ready high -> the next byte is emitted one cycle later.
REQ-039 RST_X low for 1 cycle after byte 1 of 32'hDEADBEEF -> tx_we=0, sent_cnt=0, and the next word starts again at its byte 0.
REQ-040 With CNT_W=4, send 17 console bytes -> sent_cnt wraps to 1; tx_we is never high on two consecutive cycles throughout.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, owner codes
// and the width helper for the loader's remaining-byte counter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        LD_SEND = 2'd2
    } arb_state_e;

    localparam logic OWN_LD  = 1'b0;
    localparam logic OWN_CON = 1'b1;

    // Counter must hold LD_BYTES-1; never narrower than one bit.
    function automatic int unsigned rem_width(input int unsigned n_bytes);
        if (n_bytes < 32'd3) begin
            return 32'd1;
        end else begin
            return $clog2(n_bytes);
        end
    endfunction

endpackage

// File: rtl/word_ser.sv
// Loader word serializer: holds the not-yet-sent bytes of a loader word,
// LSB first, and counts how many remain.
module word_ser
    import uart_arb_pkg::*;
#(
    parameter int LD_BYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  load,
    input  logic                  shift,
    input  logic [8*LD_BYTES-1:0] word,
    output logic [7:0]            next_byte,
    output logic                  last
);

    localparam int RW = rem_width(LD_BYTES);

    logic [8*LD_BYTES-1:0] shreg_r;
    logic [RW-1:0]         remaining_r;

    // Byte 0 leaves directly on load, so the register keeps only the upper bytes.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            shreg_r     <= '0;
            remaining_r <= '0;
        end else if (load) begin
            shreg_r     <= word >> 32'd8;
            remaining_r <= RW'(LD_BYTES - 1);
        end else if (shift) begin
            shreg_r     <= shreg_r >> 32'd8;
            remaining_r <= remaining_r - RW'(1);
        end else begin
            shreg_r     <= shreg_r;
            remaining_r <= remaining_r;
        end
    end

    assign next_byte = shreg_r[7:0];
    assign last      = (remaining_r == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx between a word-wide loader and a
// byte-wide console; loader words are sent LSB first without interleaving.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int LD_BYTES = 4,
    parameter int CNT_W    = 32
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  ld_valid,
    input  logic [8*LD_BYTES-1:0] ld_data,
    output logic                  ld_ready,
    input  logic                  con_valid,
    input  logic [7:0]            con_data,
    output logic                  con_ready,
    input  logic                  tx_ready,
    output logic                  tx_we,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  owner,
    output logic [CNT_W-1:0]      sent_cnt
);

    arb_state_e         state_r;
    arb_state_e         state_nx_s;
    logic               tx_we_r;
    logic [7:0]         tx_data_r;
    logic               owner_r;
    logic [CNT_W-1:0]   sent_cnt_r;

    logic               accept_ok_s;
    logic               ld_grant_s;
    logic               con_grant_s;
    logic               emit_s;
    logic               strobe_s;
    logic [7:0]         ser_byte_s;
    logic               ser_last_s;

    assign accept_ok_s = RST_X && (state_r == IDLE) && tx_ready && !tx_we_r;

    // On a tie the requester that was not served last wins.
    assign ld_grant_s  = accept_ok_s && ld_valid  && (!con_valid || (owner_r == OWN_CON));
    assign con_grant_s = accept_ok_s && con_valid && (!ld_valid  || (owner_r == OWN_LD));
    assign strobe_s    = ld_grant_s || con_grant_s || emit_s;

    word_ser #(
        .LD_BYTES (LD_BYTES)
    ) u_word_ser (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .load      (ld_grant_s),
        .shift     (emit_s),
        .word      (ld_data),
        .next_byte (ser_byte_s),
        .last      (ser_last_s)
    );

    // Next-state logic; LD_WAIT ignores tx_ready during the strobe cycle.
    always_comb begin
        state_nx_s = state_r;
        emit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ld_grant_s) begin
                    state_nx_s = LD_WAIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LD_WAIT: begin
                if (tx_we_r) begin
                    if (ser_last_s) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = LD_WAIT;
                    end
                end else if (tx_ready) begin
                    state_nx_s = LD_SEND;
                    emit_s     = 1'b1;
                end else begin
                    state_nx_s = LD_WAIT;
                end
            end
            LD_SEND: begin
                if (ser_last_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = LD_WAIT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Write strobe and byte presented to the UartTx.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            tx_we_r   <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            tx_we_r <= strobe_s;
            if (ld_grant_s) begin
                tx_data_r <= ld_data[7:0];
            end else if (con_grant_s) begin
                tx_data_r <= con_data;
            end else if (emit_s) begin
                tx_data_r <= ser_byte_s;
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    // Round-robin pointer; reset to console so the loader wins the first tie.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            owner_r <= OWN_CON;
        end else if (ld_grant_s) begin
            owner_r <= OWN_LD;
        end else if (con_grant_s) begin
            owner_r <= OWN_CON;
        end else begin
            owner_r <= owner_r;
        end
    end

    // Strobe counter, wrapping naturally at its width.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            sent_cnt_r <= '0;
        end else if (strobe_s) begin
            sent_cnt_r <= sent_cnt_r + CNT_W'(1);
        end else begin
            sent_cnt_r <= sent_cnt_r;
        end
    end

    assign ld_ready  = ld_grant_s;
    assign con_ready = con_grant_s;
    assign tx_we     = tx_we_r;
    assign tx_data   = tx_data_r;
    assign owner     = owner_r;
    assign sent_cnt  = sent_cnt_r;
    assign busy      = (state_r != IDLE) || tx_we_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model (pending-byte queue,
// last-served flag, strobe count) checked every cycle, plus directed scenarios.
module tb_uart_tx_arbiter;

    localparam int LDB = 4;

    logic            CLK = 1'b0;
    logic            RST_X;
    logic            ld_valid;
    logic [8*LDB-1:0] ld_data;
    logic            con_valid;
    logic [7:0]      con_data;
    logic            tx_ready;

    logic            ld_ready, con_ready, tx_we, busy, owner;
    logic [7:0]      tx_data;
    logic [31:0]     sent_cnt;

    logic            ld_ready4, con_ready4, tx_we4, busy4, owner4;
    logic [7:0]      tx_data4;
    logic [3:0]      sent_cnt4;

    uart_tx_arbiter #(.LD_BYTES(LDB), .CNT_W(32)) dut (
        .CLK(CLK), .RST_X(RST_X), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready), .tx_ready(tx_ready),
        .tx_we(tx_we), .tx_data(tx_data), .busy(busy), .owner(owner), .sent_cnt(sent_cnt)
    );

    uart_tx_arbiter #(.LD_BYTES(LDB), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST_X(RST_X), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready4),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready4), .tx_ready(tx_ready),
        .tx_we(tx_we4), .tx_data(tx_data4), .busy(busy4), .owner(owner4), .sent_cnt(sent_cnt4)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  m_q[$];
    logic        m_we = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic        m_owner = 1'b1;
    int unsigned m_cnt = 0;
    bit          m_ld_acc, m_con_acc;
    logic        prev_we = 1'b0;
    logic [7:0]  tx_log[$];
    int          ub_cnt = 0;
    bit          drop_ld, drop_con;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check();
        logic free, e_ld, e_con;
        free  = RST_X && (m_q.size() == 0) && tx_ready && !m_we;
        e_ld  = free && ld_valid  && (!con_valid || m_owner);
        e_con = free && con_valid && (!ld_valid  || !m_owner);
        cmp("ld_ready", ld_ready, e_ld);
        cmp("con_ready", con_ready, e_con);
        cmp("both_ready", ld_ready && con_ready, 0);
        cmp("tx_we", tx_we, m_we);
        cmp("tx_data", tx_data, m_data);
        cmp("busy", busy, (m_q.size() != 0) || m_we);
        cmp("owner", owner, m_owner);
        cmp("sent_cnt", sent_cnt, m_cnt);
        cmp("sent_cnt4", sent_cnt4, m_cnt % 16);
        cmp("tx_we4", tx_we4, m_we);
        cmp("we_gap", tx_we && prev_we, 0);
        if (tx_we === 1'b1) tx_log.push_back(tx_data);
        prev_we = tx_we;
    endtask

    task automatic model_step();
        logic free, a_ld, a_con, emit;
        m_ld_acc  = 1'b0;
        m_con_acc = 1'b0;
        if (!RST_X) begin
            m_q.delete();
            m_we = 1'b0; m_data = 8'h00; m_owner = 1'b1; m_cnt = 0;
            return;
        end
        free  = (m_q.size() == 0) && tx_ready && !m_we;
        emit  = (m_q.size() != 0) && tx_ready && !m_we;
        a_ld  = free && ld_valid  && (!con_valid || m_owner);
        a_con = free && con_valid && (!ld_valid  || !m_owner);
        m_we  = a_ld || a_con || emit;
        if (a_ld) begin
            m_data = ld_data[7:0];
            for (int i = 1; i < LDB; i++) m_q.push_back(ld_data[8*i +: 8]);
            m_owner = 1'b0; m_ld_acc = 1'b1;
        end else if (a_con) begin
            m_data = con_data; m_owner = 1'b1; m_con_acc = 1'b1;
        end else if (emit) begin
            m_data = m_q.pop_front();
        end
        if (m_we) m_cnt++;
    endtask

    // Inputs are changed only at the falling edge; each call spans one cycle.
    task automatic tick();
        #1;
        if (chk_en) check();
        model_step();
        @(negedge CLK);
    endtask

    task automatic uart_sim();
        if (m_we) ub_cnt = 3;
        else if (ub_cnt > 0) ub_cnt--;
        tx_ready = (ub_cnt == 0);
    endtask

    task automatic step_dir();
        tick();
        uart_sim();
        if (drop_ld && m_ld_acc) ld_valid = 1'b0;
        if (drop_con && m_con_acc) con_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST_X = 1'b0; ld_valid = 1'b0; con_valid = 1'b0; tx_ready = 1'b1;
        ub_cnt = 0; drop_ld = 1'b1; drop_con = 1'b1;
        tick(); tick();
        RST_X = 1'b1;
        tx_log.delete();
    endtask

    task automatic check_log(input string nm, input logic [7:0] exp_b[$]);
        cmp({nm, "_len"}, tx_log.size() >= exp_b.size(), 1);
        for (int i = 0; i < exp_b.size(); i++)
            if (i < tx_log.size()) cmp(nm, tx_log[i], exp_b[i]);
    endtask

    initial begin
        logic [7:0] eq[$];
        bit raised;
        int n40;
        RST_X = 1'b0; ld_valid = 1'b0; ld_data = '0; con_valid = 1'b0;
        con_data = 8'h00; tx_ready = 1'b1;
        @(negedge CLK);
        tick();
        chk_en = 1'b1;

        do_reset();
        cmp("rst_tx_we", tx_we, 0);
        cmp("rst_tx_data", tx_data, 0);
        cmp("rst_owner", owner, 1);
        cmp("rst_cnt", sent_cnt, 0);
        cmp("rst_busy", busy, 0);

        // Single word, UartTx busy for a few cycles after each byte.
        ld_valid = 1'b1; ld_data = 32'h04030201;
        for (int c = 0; c < 60; c++) step_dir();
        eq = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_log("t35", eq);
        cmp("t35_cnt", sent_cnt, 32'd4);

        // Both requesters held: loader wins the first tie, then alternation.
        do_reset();
        drop_ld = 1'b0; drop_con = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hA4A3A2A1; con_valid = 1'b1; con_data = 8'h41;
        for (int c = 0; c < 80; c++) step_dir();
        ld_valid = 1'b0; con_valid = 1'b0;
        for (int c = 0; c < 30; c++) step_dir();
        eq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h41, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h41};
        check_log("t36", eq);

        // Console arrives mid-word and must wait for the whole word.
        do_reset();
        raised = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h04030201;
        for (int c = 0; c < 80; c++) begin
            step_dir();
            if (tx_log.size() == 2 && !raised) begin
                con_valid = 1'b1; con_data = 8'h41; raised = 1'b1;
            end
        end
        eq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h41};
        check_log("t37", eq);

        // UartTx stalls for 100 cycles mid-word.
        do_reset();
        ld_valid = 1'b1; ld_data = 32'h04030201;
        for (int c = 0; c < 40 && tx_log.size() < 2; c++) step_dir();
        tx_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            cmp("t38_busy", busy, 1);
            cmp("t38_we", tx_we, 0);
        end
        tx_ready = 1'b1;
        tick();
        cmp("t38_resume_we", tx_we, 1);
        cmp("t38_resume_data", tx_data, 8'h03);
        for (int c = 0; c < 30; c++) step_dir();

        // Reset after the first byte drops the rest of the word.
        do_reset();
        ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
        for (int c = 0; c < 20 && tx_log.size() < 1; c++) step_dir();
        RST_X = 1'b0;
        tick();
        RST_X = 1'b1;
        cmp("t39_we", tx_we, 0);
        cmp("t39_cnt", sent_cnt, 0);
        tx_log.delete();
        ub_cnt = 0; tx_ready = 1'b1;
        ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
        for (int c = 0; c < 60; c++) step_dir();
        eq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        check_log("t39", eq);
        cmp("t39_cnt4", sent_cnt, 32'd4);

        // 17 console bytes on the 4-bit counter instance.
        do_reset();
        n40 = 0;
        con_valid = 1'b1;
        for (int c = 0; c < 100 && n40 < 17; c++) begin
            con_data = 8'($urandom);
            tick();
            if (m_con_acc) n40++;
        end
        con_valid = 1'b0;
        tick(); tick();
        cmp("t40_cnt4", sent_cnt4, 4'd1);
        cmp("t40_cnt", sent_cnt, 32'd17);

        // Random traffic with occasional resets and withdrawn requests.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            RST_X     = ($urandom_range(0, 299) != 0);
            ld_valid  = ($urandom_range(0, 2) == 0);
            con_valid = ($urandom_range(0, 2) == 0);
            tx_ready  = ($urandom_range(0, 3) != 0);
            ld_data   = $urandom;
            con_data  = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
